rr_arb_16_4: RTL and testbench
==============================

// Module: rr_arb_16_4
//
// PURPOSE
// Round-robin arbiter sharing one resource between 16 requesters. Produces a
// one-hot grant plus its 4-bit encoded index, the same 16:4 encoding the
// encoders produce. Holds each grant until the holder releases it, withdraws
// its request, or exceeds a hold limit. Sits in front of any shared
// datapath/bus slot that the 16:4 encoder index selects.
//
// PARAMETERS
// N         16  number of requesters (fixed; index width derived)
// IW        4   index width, log2(N)
// HOLD_MAX  8   max consecutive cycles one grant is held (>=1)
// CW        8   hold counter width; HOLD_MAX < 2**CW
//
// PORTS
// clk      in   1   clock, all logic on rising edge
// rst      in   1   synchronous active-high reset
// req      in   16  request per requester, level, held until served
// done     in   1   current holder releases grant (ignored in IDLE)
// gnt      out  16  one-hot grant, registered
// gnt_idx  out  4   encoded index of gnt, registered
// gnt_vld  out  1   high while any grant is active
// tmo      out  1   one-cycle pulse: grant removed by hold timeout
//
// BEHAVIOUR
// - Reset (rst=1 at edge): state IDLE, gnt=0, gnt_idx=0, gnt_vld=0, tmo=0,
//   ptr=0, cnt=0. Applies mid-grant: grant drops at that edge, no tmo pulse.
// - FSM with two states: IDLE, BUSY. All outputs are registers.
// - IDLE: if req!=0 at edge, winner = first set bit scanning ptr, ptr+1, ...
//   wrapping 15->0. Next cycle: BUSY, gnt=1<<w, gnt_idx=w, gnt_vld=1, cnt=0.
//   req=0: stay IDLE, outputs 0. Latency req->gnt = 1 clock.
// - BUSY, evaluated each edge in priority order:
//   1. done=1 -> release (tmo=0)
//   2. req[gnt_idx]=0 -> release (tmo=0)
//   3. cnt==HOLD_MAX-1 -> release, tmo=1 next cycle
//   4. else cnt<=cnt+1, grant unchanged
// - Release: next cycle IDLE, gnt=0, gnt_idx=0, gnt_vld=0; ptr<=gnt_idx+1
//   (mod 16, 15 wraps to 0). At least one idle cycle between grants;
//   rearbitration happens from IDLE.
// - Grant visible at most HOLD_MAX cycles; done together with timeout
//   counts as done (tmo=0). tmo is high only in the IDLE cycle after a
//   timeout release.
// - Requests from other requesters during BUSY have no effect on the grant.
// - Fairness: a requester holding req high is granted within 16 grants.
// - gnt is always one-hot or zero; gnt_idx is always the encoding of gnt.
//
// TESTING
// 1. rst=1 two cycles, req=16'hFFFF -> gnt=0, gnt_idx=0, gnt_vld=0, tmo=0.
// 2. req=16'h0001, done after 3 cycles -> gnt=0001, idx=0 one clk after
//    req; released cycle after done; ptr=1.
// 3. req=16'hFFFF held, done pulsed each grant -> idx 0,1,...,15,0 in order,
//    one IDLE cycle between each grant.
// 4. req=16'h8000 held, done=0 -> gnt_vld high exactly 8 cycles, tmo=1 one
//    cycle, idx=15 regranted after that IDLE cycle (ptr wrapped to 0).
// 5. req=16'h0404 with ptr=3 -> idx=10 wins; then drop req[10] -> release,
//    next grant idx=2.
// 6. rst=1 while BUSY at cnt=4 -> outputs 0 next cycle, tmo=0, ptr=0;
//    done=1 in IDLE has no effect.

Source files
------------

// File: rtl/rr_arb_16_4.sv
// Round-robin arbiter: 16 requesters, one-hot grant plus 4-bit index.
// Grants are held until done, request drop, or hold-limit timeout.
module rr_arb_16_4 #(
    parameter int N        = 16,
    parameter int IW       = 4,
    parameter int HOLD_MAX = 8,
    parameter int CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          done,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld,
    output logic          tmo
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic [IW-1:0] win;
    logic          found;
    logic [IW-1:0] scan;

    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);
    localparam logic [N-1:0]  ONE      = {{(N-1){1'b0}}, 1'b1};

    // Rotating first-set scan starting at ptr, wrapping via index overflow.
    always_comb begin
        win   = '0;
        found = 1'b0;
        scan  = '0;
        for (int i = 0; i < N; i++) begin
            scan = ptr + IW'(i);
            if (!found && req[scan]) begin
                win   = scan;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
            tmo     <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            tmo <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state   <= BUSY;
                        gnt     <= ONE << win;
                        gnt_idx <= win;
                        gnt_vld <= 1'b1;
                        cnt     <= '0;
                    end
                end
                BUSY: begin
                    if (done || !req[gnt_idx] || cnt == CNT_LAST) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        gnt_idx <= '0;
                        gnt_vld <= 1'b0;
                        ptr     <= gnt_idx + 1'b1;
                        tmo     <= !done && req[gnt_idx];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arb_16_4.sv
// Directed bench for rr_arb_16_4 with a grant-index scoreboard
// checked by an independent monitor on the falling edge.
module tb_rr_arb_16_4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_vld;
    logic        tmo;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    logic mon_en = 1'b0;
    logic prev_vld = 1'b0;

    rr_arb_16_4 dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .tmo     (tmo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, expv);
        end
    endtask

    // Monitor: new grant pops the scoreboard; invariants every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (gnt_vld === 1'b1 && prev_vld === 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected act=%0d exp=none", gnt_idx);
                end else begin
                    logic [3:0] e;
                    logic [15:0] eg;
                    e  = exp_q.pop_front();
                    eg = 16'h1 << e;
                    if (gnt_idx !== e || gnt !== eg) begin
                        errors++;
                        $display("FAIL sb_grant act=%0d/%h exp=%0d/%h",
                                 gnt_idx, gnt, e, eg);
                    end
                end
            end
            checks++;
            if (gnt_vld === 1'b1) begin
                if (gnt !== (16'h1 << gnt_idx)) begin
                    errors++;
                    $display("FAIL onehot act=%h exp=%h", gnt,
                             16'h1 << gnt_idx);
                end
            end else if (gnt !== 16'h0 || gnt_idx !== 4'h0) begin
                errors++;
                $display("FAIL idle_zero act=%h/%0d exp=0/0", gnt, gnt_idx);
            end
            prev_vld = gnt_vld;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        req  = 16'hFFFF;
        done = 1'b0;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_idx", 32'(gnt_idx), 32'h0);
        chk("rst_vld", 32'(gnt_vld), 32'h0);
        chk("rst_tmo", 32'(tmo), 32'h0);
        mon_en = 1'b1;
        rst = 1'b0;
        req = 16'h0;
        tick();
        chk("idle_noreq", 32'(gnt_vld), 32'h0);

        // single requester, done after 3 grant cycles
        req = 16'h0001;
        exp_q.push_back(4'd0);
        tick();
        chk("t2_latency", 32'(gnt_vld), 32'h1);
        tick();
        tick();
        done = 1'b1;
        tick();
        chk("t2_release", 32'(gnt_vld), 32'h0);
        chk("t2_tmo", 32'(tmo), 32'h0);
        done = 1'b0;

        // all requesting; ptr=1 so order starts at 1 and wraps
        req = 16'hFFFF;
        for (int k = 0; k < 17; k++) begin
            exp_q.push_back(4'((k + 1) % 16));
            tick();
            chk("t3_vld", 32'(gnt_vld), 32'h1);
            done = 1'b1;
            tick();
            chk("t3_gap", 32'(gnt_vld), 32'h0);
            done = 1'b0;
        end
        req = 16'h0;
        tick();

        // hold-limit timeout on requester 15
        req = 16'h8000;
        exp_q.push_back(4'd15);
        tick();
        chk("t4_vld0", 32'(gnt_vld), 32'h1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("t4_hold", 32'({gnt_vld, tmo}), 32'h2);
        end
        tick();
        chk("t4_tmo", 32'({gnt_vld, tmo}), 32'h1);
        exp_q.push_back(4'd15);
        tick();
        chk("t4_regrant", 32'({gnt_vld, tmo}), 32'h2);
        req = 16'h0;
        tick();
        chk("t4_drop", 32'({gnt_vld, tmo}), 32'h0);

        // set ptr=3 via a grant to 2, then 0404 must pick 10
        req = 16'h0004;
        exp_q.push_back(4'd2);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req = 16'h0404;
        exp_q.push_back(4'd10);
        tick();
        chk("t5_idx10", 32'(gnt_idx), 32'd10);
        req = 16'h0004;
        tick();
        chk("t5_release", 32'({gnt_vld, tmo}), 32'h0);
        exp_q.push_back(4'd2);
        tick();
        chk("t5_idx2", 32'(gnt_idx), 32'd2);
        done = 1'b1;
        tick();
        done = 1'b0;
        req = 16'h0;
        tick();

        // reset mid-grant at cnt=4
        req = 16'h0001;
        exp_q.push_back(4'd0);
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk("t6_busy", 32'(gnt_vld), 32'h1);
        rst = 1'b1;
        tick();
        chk("t6_rst", 32'({gnt, gnt_idx, gnt_vld, tmo}), 32'h0);
        rst = 1'b0;
        req = 16'h0;
        done = 1'b1;
        tick();
        chk("t6_done_idle", 32'({gnt_vld, tmo}), 32'h0);
        done = 1'b0;
        req = 16'hFFFF;
        exp_q.push_back(4'd0);
        tick();
        chk("t6_ptr0", 32'(gnt_idx), 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        req = 16'h0;
        tick();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
